// File: rtl/register_bank_if.sv
// Bus bundle for the general-purpose register bank: one write port driven by the
// register-select decoder, two independent registered read ports, and a sticky error flag.
interface register_bank_if;
    logic        wr_valid;
    logic [15:0] wr_onehot;
    logic [15:0] wr_data;
    logic        rd_a_valid;
    logic [2:0]  rd_a_sel;
    logic        rd_a_size;
    logic        rd_a_high_low;
    logic [15:0] rd_a_data;
    logic        rd_a_done;
    logic        rd_b_valid;
    logic [2:0]  rd_b_sel;
    logic        rd_b_size;
    logic        rd_b_high_low;
    logic [15:0] rd_b_data;
    logic        rd_b_done;
    logic        wr_err;
    logic        err_clr;

    modport master (
        output wr_valid, wr_onehot, wr_data, err_clr,
        output rd_a_valid, rd_a_sel, rd_a_size, rd_a_high_low,
        output rd_b_valid, rd_b_sel, rd_b_size, rd_b_high_low,
        input  rd_a_data, rd_a_done, rd_b_data, rd_b_done, wr_err
    );

    modport slave (
        input  wr_valid, wr_onehot, wr_data, err_clr,
        input  rd_a_valid, rd_a_sel, rd_a_size, rd_a_high_low,
        input  rd_b_valid, rd_b_sel, rd_b_size, rd_b_high_low,
        output rd_a_data, rd_a_done, rd_b_data, rd_b_done, wr_err
    );
endinterface

// File: rtl/register_bank.sv
// AX..BP register bank: one-hot word/byte writes from the decoder, two
// registered read ports with byte selection, sticky flag for malformed selects.
module register_bank #(
    parameter logic [15:0] REG_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET  = 16'hFFFE
) (
    input logic            clk,
    input logic            rst,
    register_bank_if.slave bus
);
    localparam int SP_IDX = 6;

    logic [15:0] regs [8];
    logic        wr_ok;
    logic        wr_bad;

    function automatic logic is_onehot(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, v[i]};
        end
        return cnt == 5'd1;
    endfunction

    // Byte reads of SI/DI/SP/BP have no byte alias and return zero.
    function automatic logic [15:0] read_mux(input logic [15:0] r, input logic [2:0] sel,
                                             input logic size, input logic high_low);
        logic [15:0] res;
        if (size)
            res = r;
        else if (sel[2])
            res = 16'h0000;
        else if (high_low)
            res = {8'h00, r[15:8]};
        else
            res = {8'h00, r[7:0]};
        return res;
    endfunction

    assign wr_ok  = bus.wr_valid &&  is_onehot(bus.wr_onehot);
    assign wr_bad = bus.wr_valid && !is_onehot(bus.wr_onehot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : REG_RESET;
            end
        end else if (wr_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.wr_onehot[i]) regs[i] <= bus.wr_data;
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.wr_onehot[8 + i])  regs[i][15:8] <= bus.wr_data[7:0];
                if (bus.wr_onehot[12 + i]) regs[i][7:0]  <= bus.wr_data[7:0];
            end
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.wr_err <= 1'b0;
        else if (wr_bad)
            bus.wr_err <= 1'b1;
        else if (bus.err_clr)
            bus.wr_err <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_a_data <= '0;
            bus.rd_a_done <= 1'b0;
            bus.rd_b_data <= '0;
            bus.rd_b_done <= 1'b0;
        end else begin
            bus.rd_a_done <= bus.rd_a_valid;
            bus.rd_b_done <= bus.rd_b_valid;
            if (bus.rd_a_valid)
                bus.rd_a_data <= read_mux(regs[bus.rd_a_sel], bus.rd_a_sel,
                                          bus.rd_a_size, bus.rd_a_high_low);
            if (bus.rd_b_valid)
                bus.rd_b_data <= read_mux(regs[bus.rd_b_sel], bus.rd_b_sel,
                                          bus.rd_b_size, bus.rd_b_high_low);
        end
    end
endmodule
